// File: rtl/seg7_cmd_sched.sv
// Byte-command decoder and display scheduler for the six DE1-SoC seven-segment digits.
// Host shadows, a demo hex counter on digit 0 and per-digit blinking feed registered active-low outputs.
module seg7_cmd_sched #(
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned DEMO_DIV  = 50_000_000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic       CLOCK_50,
    input  logic       Reset_7Seg,
    input  logic [7:0] Cmd_Word,
    input  logic       Cmd_Valid,
    output logic [6:0] Seg_0,
    output logic [6:0] Seg_1,
    output logic [6:0] Seg_2,
    output logic [6:0] Seg_3,
    output logic [6:0] Seg_4,
    output logic [6:0] Seg_5,
    output logic       Busy,
    output logic       Cmd_Err
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned DW = (DEMO_DIV > 1) ? $clog2(DEMO_DIV) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned NDIG = 6;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e         state_q, state_d;
    logic [2:0]     hdr_op_q, hdr_op_d;
    logic [2:0]     hdr_dig_q, hdr_dig_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [6:0]     shadow_q [NDIG];
    logic [6:0]     shadow_d [NDIG];
    logic [6:0]     seg_q [NDIG];
    logic [6:0]     seg_d [NDIG];
    logic [5:0]     mask_q, mask_d;
    logic           phase_q, phase_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           demo_en_q, demo_en_d;
    logic [3:0]     demo_cnt_q, demo_cnt_d;
    logic [DW-1:0]  demo_pre_q, demo_pre_d;
    logic           err_q, err_d;
    logic           demo_cmd;
    logic           two_byte_c;
    logic           to_expire_c;
    logic           unused_c;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Header bits [4:3] carry no meaning.
    assign unused_c    = ^Cmd_Word[4:3];
    assign two_byte_c  = (Cmd_Word[7:5] == 3'd1) || (Cmd_Word[7:5] == 3'd2) || (Cmd_Word[7:5] == 3'd4);
    // A data strobe in the expiry cycle wins over the timeout.
    assign to_expire_c = (state_q == S_WAIT) && !Cmd_Valid && (to_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50) begin
        if (Reset_7Seg) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Cmd_Valid && two_byte_c)       state_d = S_WAIT;
            S_WAIT: if (Cmd_Valid || to_expire_c)      state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shadow_d    = shadow_q;
        mask_d      = mask_q;
        hdr_op_d    = hdr_op_q;
        hdr_dig_d   = hdr_dig_q;
        demo_en_d   = demo_en_q;
        demo_cnt_d  = demo_cnt_q;
        demo_pre_d  = '0;
        demo_cmd    = 1'b0;
        err_d       = 1'b0;
        to_cnt_d    = '0;
        seg_d       = seg_q;

        if ((state_q == S_WAIT) && (state_d == S_WAIT)) to_cnt_d = to_cnt_q + 1'b1;

        if (Cmd_Valid && (state_q == S_IDLE)) begin
            hdr_op_d  = Cmd_Word[7:5];
            hdr_dig_d = Cmd_Word[2:0];
            case (Cmd_Word[7:5])
                3'd3: begin
                    if (Cmd_Word[2:0] == 3'd6) err_d = 1'b1;
                    for (int i = 0; i < int'(NDIG); i++)
                        if (Cmd_Word[2:0] == 3'd7 || Cmd_Word[2:0] == 3'(i)) shadow_d[i] = 7'h7F;
                end
                3'd5: begin
                    demo_en_d = Cmd_Word[0];
                    demo_cmd  = 1'b1;
                end
                3'd6, 3'd7: err_d = 1'b1;
                default: ;
            endcase
        end else if (Cmd_Valid) begin
            case (hdr_op_q)
                3'd1, 3'd2: begin
                    if (hdr_dig_q > 3'd5) err_d = 1'b1;
                    for (int i = 0; i < int'(NDIG); i++)
                        if (hdr_dig_q == 3'(i))
                            shadow_d[i] = (hdr_op_q == 3'd1) ? hex7(Cmd_Word[3:0]) : Cmd_Word[6:0];
                end
                default: mask_d = Cmd_Word[5:0];
            endcase
        end else if (to_expire_c) begin
            err_d = 1'b1;
        end

        blink_cnt_d = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + 1'b1;
        phase_d     = phase_q ^ (blink_cnt_q == BW'(BLINK_DIV - 1));

        // Any DEMO command restarts the prescaler and suppresses that cycle's increment.
        if (!demo_cmd && demo_en_q) begin
            if (demo_pre_q == DW'(DEMO_DIV - 1)) demo_cnt_d = demo_cnt_q + 4'd1;
            else                                 demo_pre_d = demo_pre_q + 1'b1;
        end

        for (int i = 0; i < int'(NDIG); i++) begin
            if (phase_q && mask_q[i])   seg_d[i] = 7'h7F;
            else if (i == 0 && demo_en_q) seg_d[i] = hex7(demo_cnt_q);
            else                        seg_d[i] = shadow_q[i];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset_7Seg) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                shadow_q[i] <= 7'h7F;
                seg_q[i]    <= 7'h7F;
            end
            hdr_op_q    <= '0;
            hdr_dig_q   <= '0;
            to_cnt_q    <= '0;
            mask_q      <= '0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
            demo_en_q   <= 1'b0;
            demo_cnt_q  <= '0;
            demo_pre_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            hdr_op_q    <= hdr_op_d;
            hdr_dig_q   <= hdr_dig_d;
            to_cnt_q    <= to_cnt_d;
            mask_q      <= mask_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
            demo_en_q   <= demo_en_d;
            demo_cnt_q  <= demo_cnt_d;
            demo_pre_q  <= demo_pre_d;
            err_q       <= err_d;
        end
    end

    assign Seg_0   = seg_q[0];
    assign Seg_1   = seg_q[1];
    assign Seg_2   = seg_q[2];
    assign Seg_3   = seg_q[3];
    assign Seg_4   = seg_q[4];
    assign Seg_5   = seg_q[5];
    assign Busy    = (state_q == S_WAIT);
    assign Cmd_Err = err_q;

endmodule

// File: tb/tb_seg7_cmd_sched.sv
// Self-checking bench for seg7_cmd_sched: directed scenarios plus random command streams
// compared against a cycle-indexed model built from the command rules.
module tb_seg7_cmd_sched;

    localparam int BD = 4;
    localparam int DD = 8;
    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] word = 8'h00;
    logic [6:0] s0, s1, s2, s3, s4, s5;
    logic       busy, err;

    always #5 clk = ~clk;

    seg7_cmd_sched #(.BLINK_DIV(BD), .DEMO_DIV(DD), .TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .Reset_7Seg(rst), .Cmd_Word(word), .Cmd_Valid(valid),
        .Seg_0(s0), .Seg_1(s1), .Seg_2(s2), .Seg_3(s3), .Seg_4(s4), .Seg_5(s5),
        .Busy(busy), .Cmd_Err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: k = clock edges since the reset edge; register values are functions of k.
    int         k;
    logic [6:0] m_sh [6];
    logic [5:0] m_mask;
    bit         m_demo_en;
    int         m_demo_base, m_demo_edge;
    bit         m_wait;
    logic [7:0] m_hdr;
    int         m_hdr_edge;
    logic [6:0] e_seg [6];
    bit         e_busy, e_err;

    function automatic bit phase_at(input int kk);
        return ((kk / BD) % 2) == 1;
    endfunction

    function automatic int demo_at(input int kk);
        if (m_demo_en) return (m_demo_base + (kk - m_demo_edge) / DD) % 16;
        return m_demo_base;
    endfunction

    function automatic logic [43:0] pack_dut();
        return {s5, s4, s3, s2, s1, s0, busy, err};
    endfunction

    function automatic logic [43:0] pack_exp();
        return {e_seg[5], e_seg[4], e_seg[3], e_seg[2], e_seg[1], e_seg[0], e_busy, e_err};
    endfunction

    // Drive one cycle of input, then advance the model to the state after that edge.
    task automatic step(input bit r, input bit v, input logic [7:0] w);
        int d;
        rst = r; valid = v; word = w;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0; word = 8'h00;
        if (r) begin
            k = 0;
            for (int i = 0; i < 6; i++) begin m_sh[i] = 7'h7F; e_seg[i] = 7'h7F; end
            m_mask = '0; m_demo_en = 0; m_demo_base = 0; m_demo_edge = 0; m_wait = 0;
            e_busy = 0; e_err = 0;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            if (phase_at(k) && m_mask[i])   e_seg[i] = 7'h7F;
            else if (i == 0 && m_demo_en)   e_seg[i] = hex_tab[demo_at(k)];
            else                            e_seg[i] = m_sh[i];
        end
        e_err = 0;
        if (m_wait) begin
            if (v) begin
                m_wait = 0;
                d = int'(m_hdr[2:0]);
                case (m_hdr[7:5])
                    3'd1: if (d < 6) m_sh[d] = hex_tab[w[3:0]]; else e_err = 1;
                    3'd2: if (d < 6) m_sh[d] = w[6:0]; else e_err = 1;
                    default: m_mask = w[5:0];
                endcase
            end else if (k + 1 - m_hdr_edge == TO) begin
                m_wait = 0; e_err = 1;
            end
        end else if (v) begin
            d = int'(w[2:0]);
            case (w[7:5])
                3'd1, 3'd2, 3'd4: begin m_wait = 1; m_hdr = w; m_hdr_edge = k + 1; end
                3'd3: begin
                    if (d == 7) for (int i = 0; i < 6; i++) m_sh[i] = 7'h7F;
                    else if (d == 6) e_err = 1;
                    else m_sh[d] = 7'h7F;
                end
                3'd5: begin m_demo_base = demo_at(k); m_demo_en = w[0]; m_demo_edge = k + 1; end
                3'd6, 3'd7: e_err = 1;
                default: ;
            endcase
        end
        k++;
        e_busy = m_wait;
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00);
            n_cmp++;
            if (pack_dut() !== {42'h3FF_FFFF_FFFF, 2'b00}) begin
                n_bad++;
                $display("FAIL reset_idle cyc %0d: got %h expected all-7F busy=0 err=0", i, pack_dut());
            end
        end
    endtask

    task automatic test_write_hex();
        step(0, 1, 8'h22);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL hex_busy_hi: got %b expected 1", busy); end
        step(0, 1, 8'h0A);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL hex_busy_lo: got %b expected 0", busy); end
        step(0, 0, 8'h00);
        n_cmp++;
        if ({s5, s4, s3, s2, s1, s0} !== {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h7F, 7'h7F}) begin
            n_bad++;
            $display("FAIL hex_seg: got %h %h %h %h %h %h expected 7f 7f 7f 08 7f 7f", s5, s4, s3, s2, s1, s0);
        end
        n_cmp++;
        if (pack_dut() !== pack_exp()) begin n_bad++; $display("FAIL hex_model: got %h expected %h", pack_dut(), pack_exp()); end
    endtask

    task automatic test_invalid_digit();
        step(0, 1, 8'h47);
        step(0, 1, 8'h00);
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL raw_d7_err: got %b expected 1", err); end
        step(0, 0, 8'h00);
        n_cmp++;
        if (pack_dut() !== pack_exp() || err !== 1'b0 || s2 !== 7'h08) begin
            n_bad++; $display("FAIL raw_d7_after: got %h expected %h", pack_dut(), pack_exp());
        end
        step(0, 1, 8'h67);
        step(0, 0, 8'h00);
        n_cmp++;
        if ({s5, s4, s3, s2, s1, s0} !== 42'h3FF_FFFF_FFFF) begin
            n_bad++; $display("FAIL blank_all: got %h %h %h %h %h %h expected all 7f", s5, s4, s3, s2, s1, s0);
        end
    endtask

    task automatic test_timeout();
        step(0, 1, 8'h21);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00);
        n_cmp++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL to_before: got busy=%b err=%b expected busy=1 err=0", busy, err);
        end
        step(0, 0, 8'h00);
        n_cmp++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            n_bad++; $display("FAIL to_expire: got busy=%b err=%b expected busy=0 err=1", busy, err);
        end
        step(0, 1, 8'h21);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00);
        step(0, 1, 8'h03);
        n_cmp++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL to_data_wins: got busy=%b err=%b expected busy=0 err=0", busy, err);
        end
        step(0, 0, 8'h00);
        n_cmp++;
        if (s1 !== 7'h30) begin n_bad++; $display("FAIL to_seg1: got %h expected 30", s1); end
    endtask

    task automatic test_demo();
        logic [6:0] seen [$];
        logic [6:0] last;
        last = s0;
        step(0, 1, 8'hA1);
        for (int i = 0; i < 160 && seen.size() < 17; i++) begin
            step(0, 0, 8'h00);
            n_cmp++;
            if (pack_dut() !== pack_exp()) begin n_bad++; $display("FAIL demo_model cyc %0d: got %h expected %h", i, pack_dut(), pack_exp()); end
            if (s0 !== last) begin seen.push_back(s0); last = s0; end
        end
        n_cmp++;
        if (seen.size() != 17) begin n_bad++; $display("FAIL demo_count: got %0d values expected 17", seen.size()); end
        for (int j = 0; j < seen.size(); j++) begin
            n_cmp++;
            if (seen[j] !== hex_tab[j % 16]) begin n_bad++; $display("FAIL demo_seq %0d: got %h expected %h", j, seen[j], hex_tab[j % 16]); end
        end
        step(0, 1, 8'h20);
        step(0, 1, 8'h05);
        step(0, 0, 8'h00);
        n_cmp++;
        if (pack_dut() !== pack_exp()) begin n_bad++; $display("FAIL demo_hostwr: got %h expected %h", pack_dut(), pack_exp()); end
        step(0, 1, 8'hA0);
        step(0, 0, 8'h00);
        n_cmp++;
        if (s0 !== 7'h12) begin n_bad++; $display("FAIL demo_off_seg0: got %h expected 12", s0); end
    endtask

    task automatic test_blink();
        logic [6:0] last;
        int         last_chg;
        int         nchg;
        step(0, 1, 8'h23);
        step(0, 1, 8'h08);
        step(0, 1, 8'h80);
        step(0, 1, 8'h08);
        last = s3; last_chg = -1; nchg = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 8'h00);
            n_cmp++;
            if (pack_dut() !== pack_exp() || (s3 !== 7'h00 && s3 !== 7'h7F)) begin
                n_bad++; $display("FAIL blink_model cyc %0d: got %h expected %h", i, pack_dut(), pack_exp());
            end
            if (s3 !== last) begin
                if (last_chg >= 0) begin
                    n_cmp++;
                    if (i - last_chg != BD) begin n_bad++; $display("FAIL blink_period: got %0d expected %0d", i - last_chg, BD); end
                end
                last_chg = i; last = s3; nchg++;
            end
        end
        n_cmp++;
        if (nchg < 4) begin n_bad++; $display("FAIL blink_toggles: got %0d expected >=4", nchg); end
        step(1, 1, 8'hA1);
        step(0, 0, 8'h00);
        n_cmp++;
        if (pack_dut() !== {42'h3FF_FFFF_FFFF, 2'b00}) begin n_bad++; $display("FAIL blink_reset: got %h expected all-7F idle", pack_dut()); end
        step(0, 1, 8'h23);
        step(1, 0, 8'h00);
        step(0, 1, 8'h08);
        n_cmp++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL midcmd_reset: got busy=%b err=%b expected busy=0 err=0", busy, err);
        end
        step(0, 0, 8'h00);
        n_cmp++;
        if (pack_dut() !== {42'h3FF_FFFF_FFFF, 2'b00}) begin n_bad++; $display("FAIL midcmd_seg: got %h expected all-7F idle", pack_dut()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [8] = '{8'h24, 8'h0F, 8'h55, 8'h77, 8'h64, 8'hC0, 8'h66, 8'h33};
        for (int i = 0; i < 8; i++) begin
            step(0, 1, seq[i]);
            n_cmp++;
            if (pack_dut() !== pack_exp()) begin n_bad++; $display("FAIL b2b %0d: got %h expected %h", i, pack_dut(), pack_exp()); end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00);
            n_cmp++;
            if (pack_dut() !== pack_exp()) begin n_bad++; $display("FAIL b2b_tail %0d: got %h expected %h", i, pack_dut(), pack_exp()); end
        end
    endtask

    task automatic test_random();
        bit         r, v;
        logic [7:0] w;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 99) < 35);
            w = 8'($urandom);
            step(r, v, w);
            n_cmp++;
            if (pack_dut() !== pack_exp()) begin
                n_bad++; $display("FAIL random %0d (r=%b v=%b w=%h): got %h expected %h", i, r, v, w, pack_dut(), pack_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_hex();
        test_invalid_digit();
        test_timeout();
        test_demo();
        test_blink();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
